// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP gray-scale path: RGB565 field positions,
// luma coefficients, mode encodings and the pipeline stage payloads.
package dvp_pkg;

  // RGB565 field positions
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Fixed-point luma: gs = (77*R + 150*G + 29*B + 128) >> 8
  // The coefficients sum to 256, so full-scale white maps to exactly 255.
  localparam int COEF_R     = 77;
  localparam int COEF_G     = 150;
  localparam int COEF_B     = 29;
  localparam int LUMA_SHIFT = 8;
  localparam int LUMA_RND   = 128;

  typedef enum logic {
    GS_MODE_LUMA  = 1'b0,
    GS_MODE_GREEN = 1'b1
  } gs_mode_e;

  // S1 payload: channels expanded to 8 bits plus the sampled mode
  typedef struct packed {
    gs_mode_e   mode;
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
  } s1_t;

  // S2 payload: weighted products; g8 rides along for green-only mode
  typedef struct packed {
    gs_mode_e    mode;
    logic [14:0] pr;
    logic [15:0] pg;
    logic [12:0] pb;
    logic [7:0]  g8;
  } s2_t;

  // Replicate the top bits into the new LSBs so 0 maps to 0 and full scale to 255
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/dvp_pipe_stage.sv
// One elastic valid/ready register slice. A stage loads whenever it is empty
// or its downstream neighbour is loading, so bubbles collapse and a full
// pipeline still moves one item per cycle.
module dvp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld_i,
  input  logic [W-1:0] up_data_i,
  input  logic         dn_ld_i,
  output logic         ld_o,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         v_q;
  logic         v_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign ld_o   = ~v_q | dn_ld_i;
  assign vld_o  = v_q;
  assign data_o = data_q;

  // Next state: take upstream contents on load, otherwise hold
  always_comb begin
    // NOTE: defaults first so every path assigns v_d/data_d; a missing branch would infer a latch.
    v_d    = v_q;
    data_d = data_q;
    if (ld_o) begin
      v_d = up_vld_i;
      if (up_vld_i) begin
        data_d = up_data_i;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      // NOTE: data is cleared as well as the valid bit so the output reads 0 after reset.
      data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together on the edge.
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/dvp_gray_scale.sv
// RGB565 to 8-bit gray-scale converter. Three elastic stages:
// S1 expands the channels, S2 forms the weighted products and S3 sums and
// rounds (or passes green through). It also keeps a saturating count of
// delivered output pixels.
module dvp_gray_scale
  import dvp_pkg::*;
#(
  parameter int RGB_PXL_W = 16,
  parameter int GS_PXL_W  = 8,
  parameter int PXL_CNT_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RGB_PXL_W-1:0] rgb_pxl_i,
  input  logic                 rgb_pxl_vld_i,
  output logic                 rgb_pxl_rdy_o,
  input  logic                 dcr_gs_mode_i,
  input  logic                 cnt_clr_i,
  output logic [GS_PXL_W-1:0]  gs_pxl_o,
  output logic                 gs_pxl_vld_o,
  input  logic                 gs_pxl_rdy_i,
  output logic [PXL_CNT_W-1:0] gs_pxl_cnt_o
);

  s1_t                 s1_in;
  s1_t                 s1_q;
  s2_t                 s2_in;
  s2_t                 s2_q;
  logic [GS_PXL_W-1:0] s3_in;
  logic [15:0]         luma_sum;
  logic                v1;
  logic                v2;
  logic                ld2;
  logic                ld3;
  logic                out_hs;
  logic [PXL_CNT_W-1:0] cnt_q;
  logic [PXL_CNT_W-1:0] cnt_d;

  // S1 input: expand RGB565 channels to 8 bits and sample the mode
  always_comb begin
    s1_in.mode = gs_mode_e'(dcr_gs_mode_i);
    s1_in.r8   = expand5(rgb_pxl_i[R_MSB:R_LSB]);
    s1_in.g8   = expand6(rgb_pxl_i[G_MSB:G_LSB]);
    s1_in.b8   = expand5(rgb_pxl_i[B_MSB:B_LSB]);
  end

  dvp_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .up_vld_i  (rgb_pxl_vld_i),
    .up_data_i (s1_in),
    .dn_ld_i   (ld2),
    .ld_o      (rgb_pxl_rdy_o),
    .vld_o     (v1),
    .data_o    (s1_q)
  );

  // S2 input: unsigned weighted products, widths sized for 255 * coefficient
  always_comb begin
    s2_in.mode = s1_q.mode;
    s2_in.pr   = 15'(s1_q.r8) * 15'(COEF_R);
    s2_in.pg   = 16'(s1_q.g8) * 16'(COEF_G);
    s2_in.pb   = 13'(s1_q.b8) * 13'(COEF_B);
    s2_in.g8   = s1_q.g8;
  end

  dvp_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .up_vld_i  (v1),
    .up_data_i (s2_in),
    .dn_ld_i   (ld3),
    .ld_o      (ld2),
    .vld_o     (v2),
    .data_o    (s2_q)
  );

  // S3 input: rounded luma (peak sum 65408 fits in 16 bits) or raw green
  always_comb begin
    luma_sum = 16'(s2_q.pr) + s2_q.pg + 16'(s2_q.pb) + 16'(LUMA_RND);
    if (s2_q.mode == GS_MODE_GREEN) begin
      s3_in = GS_PXL_W'(s2_q.g8);
    end else begin
      s3_in = GS_PXL_W'(luma_sum >> LUMA_SHIFT);
    end
  end

  dvp_pipe_stage #(.W(GS_PXL_W)) u_s3 (
    .clk       (clk),
    .rst       (rst),
    .up_vld_i  (v2),
    .up_data_i (s3_in),
    .dn_ld_i   (gs_pxl_rdy_i),
    .ld_o      (ld3),
    .vld_o     (gs_pxl_vld_o),
    .data_o    (gs_pxl_o)
  );

  assign out_hs       = gs_pxl_vld_o & gs_pxl_rdy_i;
  assign gs_pxl_cnt_o = cnt_q;

  // Delivered-pixel counter: clear has priority, saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (out_hs && (cnt_q != '1)) begin
      cnt_d = cnt_q + PXL_CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dvp_gray_scale.sv
// Self-checking bench for dvp_gray_scale: directed RGB565 vectors with
// hand-computed gray values, a scoreboard queue filled at input acceptance
// and drained by an output monitor.
module tb_dvp_gray_scale;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rgb_pxl_i = '0;
  logic        rgb_pxl_vld_i = 1'b0;
  logic        rgb_pxl_rdy_o;
  logic        dcr_gs_mode_i = 1'b0;
  logic        cnt_clr_i = 1'b0;
  logic [7:0]  gs_pxl_o;
  logic        gs_pxl_vld_o;
  logic        gs_pxl_rdy_i = 1'b1;
  logic [19:0] gs_pxl_cnt_o;

  logic        sm_rgb_rdy;
  logic [7:0]  sm_gs_pxl;
  logic        sm_gs_vld;
  logic [3:0]  sm_cnt;

  always #5 clk = ~clk;

  dvp_gray_scale dut (
    .clk           (clk),
    .rst           (rst),
    .rgb_pxl_i     (rgb_pxl_i),
    .rgb_pxl_vld_i (rgb_pxl_vld_i),
    .rgb_pxl_rdy_o (rgb_pxl_rdy_o),
    .dcr_gs_mode_i (dcr_gs_mode_i),
    .cnt_clr_i     (cnt_clr_i),
    .gs_pxl_o      (gs_pxl_o),
    .gs_pxl_vld_o  (gs_pxl_vld_o),
    .gs_pxl_rdy_i  (gs_pxl_rdy_i),
    .gs_pxl_cnt_o  (gs_pxl_cnt_o)
  );

  // Narrow-counter copy driven by the same stimulus, used for saturation
  dvp_gray_scale #(.PXL_CNT_W(4)) dut_small (
    .clk           (clk),
    .rst           (rst),
    .rgb_pxl_i     (rgb_pxl_i),
    .rgb_pxl_vld_i (rgb_pxl_vld_i),
    .rgb_pxl_rdy_o (sm_rgb_rdy),
    .dcr_gs_mode_i (dcr_gs_mode_i),
    .cnt_clr_i     (cnt_clr_i),
    .gs_pxl_o      (sm_gs_pxl),
    .gs_pxl_vld_o  (sm_gs_vld),
    .gs_pxl_rdy_i  (gs_pxl_rdy_i),
    .gs_pxl_cnt_o  (sm_cnt)
  );

  typedef struct {
    logic [15:0] pix;
    logic        mode;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [10] = '{
    '{16'hFFFF, 1'b0, 8'd255},
    '{16'h0000, 1'b0, 8'd0},
    '{16'hF800, 1'b0, 8'd77},
    '{16'h07E0, 1'b0, 8'd149},
    '{16'h001F, 1'b0, 8'd29},
    '{16'h07E0, 1'b1, 8'd255},
    '{16'h0400, 1'b1, 8'd130},
    '{16'hF800, 1'b1, 8'd0},
    '{16'h0400, 1'b0, 8'd76},
    '{16'h8410, 1'b0, 8'd131}
  };

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         n_acc = 0;
  int         n_out = 0;
  int         first_acc = -1;
  int         out_cyc [$];
  logic [7:0] sb [$];
  logic [7:0] cur_exp = '0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_gs = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: record the expected value of every pixel about to be accepted
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (rgb_pxl_vld_i && rgb_pxl_rdy_o) begin
      sb.push_back(cur_exp);
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
  end

  // Monitor: compare every output handshake and check stall stability
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_vld_held", 32'(gs_pxl_vld_o), 32'd1);
        check("stall_data_stable", 32'(gs_pxl_o), 32'(prev_gs));
      end
      if (gs_pxl_vld_o && gs_pxl_rdy_i) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel: got %0d expected no output", gs_pxl_o);
        end else begin
          check("gs_pxl", 32'(gs_pxl_o), 32'(sb.pop_front()));
        end
      end
      prev_stall = gs_pxl_vld_o && !gs_pxl_rdy_i;
      prev_gs    = gs_pxl_o;
    end
  end

  task automatic send(input logic [15:0] p, input logic m, input logic [7:0] e);
    int t;
    t = 0;
    rgb_pxl_i     = p;
    dcr_gs_mode_i = m;
    cur_exp       = e;
    rgb_pxl_vld_i = 1'b1;
    @(negedge clk);
    while (!rgb_pxl_rdy_o) begin
      t++;
      if (t > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got no ready expected ready within 50 cycles");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rgb_pxl_vld_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || gs_pxl_vld_o) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int nout0;
    int t;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_gs_vld", 32'(gs_pxl_vld_o), 32'd0);
    check("rst_gs_pxl", 32'(gs_pxl_o), 32'd0);
    check("rst_cnt", 32'(gs_pxl_cnt_o), 32'd0);
    rst = 1'b0;
    check("rst_rgb_rdy", 32'(rgb_pxl_rdy_o), 32'd1);
    @(posedge clk);
    #1;

    // Basic luma vectors, latency and throughput
    first_acc = -1;
    out_cyc.delete();
    for (int i = 0; i < 5; i++) send(vecs[i].pix, vecs[i].mode, vecs[i].exp);
    drain();
    check("t1_out_count", 32'(out_cyc.size()), 32'd5);
    if (out_cyc.size() >= 5) begin
      check("t1_latency", 32'(out_cyc[0] - first_acc), 32'd3);
      check("t1_back_to_back", 32'(out_cyc[4] - out_cyc[0]), 32'd4);
    end
    check("t1_cnt", 32'(gs_pxl_cnt_o), 32'd5);

    // Green-only mode
    send(vecs[5].pix, vecs[5].mode, vecs[5].exp);
    send(vecs[6].pix, vecs[6].mode, vecs[6].exp);
    drain();
    check("t2_cnt", 32'(gs_pxl_cnt_o), 32'd7);

    // Stall: downstream not ready while 10 pixels stream in
    gs_pxl_rdy_i = 1'b0;
    base  = n_acc;
    nout0 = n_out;
    fork
      for (int i = 0; i < 10; i++) send(vecs[i].pix, vecs[i].mode, vecs[i].exp);
      begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #2;
          check("stall_rgb_rdy", 32'(rgb_pxl_rdy_o), 32'((n_acc - base) < 3));
        end
        gs_pxl_rdy_i = 1'b1;
      end
    join
    drain();
    check("t3_out_count", 32'(n_out - nout0), 32'd10);

    // Mode toggled every pixel on a pure red stream
    for (int i = 0; i < 6; i++) send(16'hF800, i[0], i[0] ? 8'd0 : 8'd77);
    drain();

    // Reset with three pixels held in flight
    gs_pxl_rdy_i = 1'b0;
    send(vecs[0].pix, vecs[0].mode, vecs[0].exp);
    send(vecs[2].pix, vecs[2].mode, vecs[2].exp);
    send(vecs[3].pix, vecs[3].mode, vecs[3].exp);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("inflight_rst_vld", 32'(gs_pxl_vld_o), 32'd0);
    check("inflight_rst_cnt", 32'(gs_pxl_cnt_o), 32'd0);
    check("inflight_rst_rgb_rdy", 32'(rgb_pxl_rdy_o), 32'd1);
    rst = 1'b0;
    gs_pxl_rdy_i = 1'b1;
    nout0 = n_out;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_pixel", 32'(n_out - nout0), 32'd0);

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) send(vecs[i % 10].pix, vecs[i % 10].mode, vecs[i % 10].exp);
    drain();
    check("cnt_20", 32'(gs_pxl_cnt_o), 32'd20);
    check("cnt_sat_15", 32'(sm_cnt), 32'd15);

    // Plain clear
    cnt_clr_i = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr_i = 1'b0;
    check("clr_cnt", 32'(gs_pxl_cnt_o), 32'd0);
    check("clr_cnt_small", 32'(sm_cnt), 32'd0);

    // Clear in the same cycle as an output handshake
    fork
      for (int i = 0; i < 6; i++) send(vecs[i].pix, vecs[i].mode, vecs[i].exp);
      begin
        t = 0;
        @(negedge clk);
        while (!gs_pxl_vld_o && t < 50) begin
          @(negedge clk);
          t++;
        end
        check("clr_hs_present", 32'(gs_pxl_vld_o && gs_pxl_rdy_i), 32'd1);
        cnt_clr_i = 1'b1;
        @(posedge clk);
        #2;
        check("clr_wins_cnt", 32'(gs_pxl_cnt_o), 32'd0);
        check("clr_wins_cnt_small", 32'(sm_cnt), 32'd0);
        cnt_clr_i = 1'b0;
      end
    join
    drain();
    check("cnt_after_clr", 32'(gs_pxl_cnt_o), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within 500000 time units");
    $fatal(1, "simulation time limit reached");
  end

endmodule
